hazard_control_unit: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32I core; companion to the forwarding unit. Detects hazards that forwarding cannot cover and drives per-stage write-enable/flush controls:
- load-use stall
- taken-branch/jump flush
- multi-cycle data-memory wait, with a timeout watchdog

Also keeps saturating stall/flush performance counters.

---
 rtl/hazard_control_unit.sv | 144 ++++++++++++++
 tb/tb_hazard_control_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use stall,
// taken-branch flush, data-memory wait freeze with a timeout watchdog, and saturating stall/flush counters.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             EX_branch_taken,
  input  logic             EX_MEM_MemAccess,
  input  logic             dmem_ready,
  input  logic             clr_counters,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             MEM_WB_flush,
  output logic             busy_wait,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN, WAIT} state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              miss, mem_done, freeze, timeout_fire;
  logic              lu, branch_act, lu_act;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign miss     = EX_MEM_MemAccess && !dmem_ready;
  // A dropped access request while waiting releases the freeze just like ready.
  assign mem_done = dmem_ready || !EX_MEM_MemAccess;

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    freeze        = 1'b0;
    timeout_fire  = 1'b0;
    case (state)
      RUN: begin
        if (miss) begin
          freeze        = 1'b1;
          state_next    = WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      WAIT: begin
        if (mem_done) begin
          state_next = RUN;
        end else if ((MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT))) begin
          timeout_fire = 1'b1;
          state_next   = RUN;
        end else begin
          freeze        = 1'b1;
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign lu = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
              ((ID_uses_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
               (ID_uses_rs2 && (IF_ID_rs2 == ID_EX_rd)));

  // Priority: memory freeze, then branch flush, then load-use.
  assign branch_act = !freeze && EX_branch_taken;
  assign lu_act     = !freeze && !EX_branch_taken && lu;

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_write  = 1'b1;
    ID_EX_flush  = 1'b0;
    EX_MEM_write = 1'b1;
    MEM_WB_flush = 1'b0;
    busy_wait    = 1'b0;
    if (!rst_n) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_write  = 1'b0;
      ID_EX_flush  = 1'b1;
      EX_MEM_write = 1'b0;
      MEM_WB_flush = 1'b1;
    end else if (freeze) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_flush = 1'b1;
      busy_wait    = 1'b1;
    end else if (branch_act) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (lu_act) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (timeout_fire) mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_counters) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze || lu_act) stall_cnt <= sat_inc(stall_cnt);
      if (branch_act)       flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: one instance with MEM_TIMEOUT=4/CNT_W=4,
// a second with the watchdog disabled, both driven by the same stimulus.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic       ID_uses_rs1, ID_uses_rs2, ID_EX_MemRead, EX_branch_taken;
  logic       EX_MEM_MemAccess, dmem_ready, clr_counters;

  logic       PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush;
  logic       EX_MEM_write, MEM_WB_flush, busy_wait, mem_timeout;
  logic [3:0] stall_cnt, flush_cnt;

  logic       z_pc, z_ifw, z_iff, z_idw, z_idf, z_exw, z_mwf, z_busy, z_mt;
  logic [15:0] z_stall, z_flush;

  logic [7:0] ctl, ctl0;
  int checks = 0;
  int failures = 0;

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write, MEM_WB_flush, busy_wait}
  localparam logic [7:0] C_RST = 8'b0010_1010;
  localparam logic [7:0] C_DEF = 8'b1101_0100;
  localparam logic [7:0] C_LU  = 8'b0001_1100;
  localparam logic [7:0] C_BR  = 8'b1111_1100;
  localparam logic [7:0] C_FRZ = 8'b0000_0011;

  assign ctl  = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
                 EX_MEM_write, MEM_WB_flush, busy_wait};
  assign ctl0 = {z_pc, z_ifw, z_iff, z_idw, z_idf, z_exw, z_mwf, z_busy};

  always #5 clk = ~clk;

  hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .ID_EX_rd(ID_EX_rd), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_branch_taken(EX_branch_taken), .EX_MEM_MemAccess(EX_MEM_MemAccess),
    .dmem_ready(dmem_ready), .clr_counters(clr_counters),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_write(ID_EX_write), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_write(EX_MEM_write), .MEM_WB_flush(MEM_WB_flush),
    .busy_wait(busy_wait), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_control_unit #(.MEM_TIMEOUT(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .ID_EX_rd(ID_EX_rd), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_branch_taken(EX_branch_taken), .EX_MEM_MemAccess(EX_MEM_MemAccess),
    .dmem_ready(dmem_ready), .clr_counters(clr_counters),
    .PC_write(z_pc), .IF_ID_write(z_ifw), .IF_ID_flush(z_iff),
    .ID_EX_write(z_idw), .ID_EX_flush(z_idf),
    .EX_MEM_write(z_exw), .MEM_WB_flush(z_mwf),
    .busy_wait(z_busy), .mem_timeout(z_mt),
    .stall_cnt(z_stall), .flush_cnt(z_flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0; ID_EX_rd = 5'd0;
    ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0; ID_EX_MemRead = 1'b0;
    EX_branch_taken = 1'b0; EX_MEM_MemAccess = 1'b0; dmem_ready = 1'b1;
    clr_counters = 1'b0;
  endtask

  task automatic set_lu1();
    IF_ID_rs1 = 5'd5; ID_EX_rd = 5'd5; ID_EX_MemRead = 1'b1; ID_uses_rs1 = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    chk("rst_ctl", ctl, C_RST);
    chk("rst_ctl0", ctl0, C_RST);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_mt", mem_timeout, 0);

    nxt(); rst_n = 1'b1; #1;
    chk("def_ctl", ctl, C_DEF);

    // load-use on rs1
    nxt(); set_lu1(); #1;
    chk("lu_ctl", ctl, C_LU);
    nxt(); idle(); #1;
    chk("lu_stall", stall_cnt, 1);
    chk("lu_release", ctl, C_DEF);
    // rd = x0 never stalls
    set_lu1(); ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0; #1;
    chk("lu_rd0", ctl, C_DEF);
    // rs1 not used
    nxt(); set_lu1(); ID_uses_rs1 = 1'b0; #1;
    chk("lu_nouse", ctl, C_DEF);
    // load-use on rs2
    nxt(); idle(); IF_ID_rs2 = 5'd9; ID_EX_rd = 5'd9; ID_EX_MemRead = 1'b1; ID_uses_rs2 = 1'b1; #1;
    chk("lu_rs2", ctl, C_LU);
    nxt(); idle(); #1;
    chk("lu_rs2_stall", stall_cnt, 2);

    // branch overrides load-use
    set_lu1(); EX_branch_taken = 1'b1; #1;
    chk("br_ctl", ctl, C_BR);
    nxt(); idle(); #1;
    chk("br_flush", flush_cnt, 1);
    chk("br_stall", stall_cnt, 2);

    // 3-cycle memory wait
    EX_MEM_MemAccess = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_frz%0d", i), ctl, C_FRZ);
      nxt();
    end
    dmem_ready = 1'b1; #1;
    chk("mw_ready", ctl, C_DEF);
    nxt(); idle(); #1;
    chk("mw_stall", stall_cnt, 5);

    // watchdog: 4 freeze cycles then forced release; disabled instance stays frozen
    EX_MEM_MemAccess = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to_frz%0d", i), ctl, C_FRZ);
      nxt();
    end
    #1;
    chk("to_release", ctl, C_DEF);
    chk("to_mt_before", mem_timeout, 0);
    chk("to_dis_frz", ctl0, C_FRZ);
    nxt(); idle(); #1;
    chk("to_mt", mem_timeout, 1);
    chk("to_dis_mt", z_mt, 0);
    chk("to_stall", stall_cnt, 9);
    chk("to_drop_ctl0", ctl0, C_DEF);

    // branch held during freeze, flushes on release
    nxt(); EX_MEM_MemAccess = 1'b1; dmem_ready = 1'b0; EX_branch_taken = 1'b1; #1;
    chk("bf_frz", ctl, C_FRZ);
    nxt(); dmem_ready = 1'b1; #1;
    chk("bf_release", ctl, C_BR);
    nxt(); idle(); #1;
    chk("bf_flush", flush_cnt, 2);
    chk("bf_stall", stall_cnt, 10);
    chk("mt_sticky", mem_timeout, 1);

    // saturation then clear with a concurrent stall
    set_lu1();
    for (int i = 0; i < 20; i++) nxt();
    #1;
    chk("sat_stall", stall_cnt, 15);
    clr_counters = 1'b1;
    nxt(); idle(); #1;
    chk("clr_stall", stall_cnt, 0);
    chk("clr_flush", flush_cnt, 0);

    // reset in the middle of a memory wait
    EX_MEM_MemAccess = 1'b1; dmem_ready = 1'b0;
    nxt(); nxt(); #1;
    chk("rw_stall", stall_cnt, 2);
    chk("rw_frz", ctl, C_FRZ);
    #1; rst_n = 1'b0; #1;
    chk("rw_ctl", ctl, C_RST);
    chk("rw_ctl0", ctl0, C_RST);
    chk("rw_stall0", stall_cnt, 0);
    chk("rw_mt", mem_timeout, 0);
    nxt(); idle(); rst_n = 1'b1; #1;
    chk("rw_def", ctl, C_DEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
